// File: rtl/seven_segment_capture.sv
// seven_segment_capture
// Receiving end of an active-low multiplexed 8-digit seven-segment display.
// It samples the anode and cathode lines and rebuilds the displayed 32-bit hex
// value, a per-digit blank mask and a sticky decode-error flag. Results update
// atomically, once per complete scan of all eight digits.
// Optional feature: define SEVEN_SEGMENT_CAPTURE_DP_EN to add the decimal-point
// input dp_in and the per-digit output dp_out.
//
// state   | meaning
// COLLECT | accumulate accepted digits into the shadow frame; run the timeout
// COMMIT  | one cycle: copy the shadow frame to the outputs, clear seen

module seven_segment_capture #(
    parameter int unsigned SETTLE_CYCLES  = 16,
    parameter int unsigned TIMEOUT_CYCLES = 2000000
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic [7:0]  an_in,
    input  logic [6:0]  cat_in,
`ifdef SEVEN_SEGMENT_CAPTURE_DP_EN
    input  logic        dp_in,
    output logic [7:0]  dp_out,
`endif
    output logic [31:0] value_out,
    output logic [7:0]  blank_out,
    output logic        frame_valid_out,
    output logic        error_out,
    output logic        stale_out
);

`ifdef SEVEN_SEGMENT_CAPTURE_DP_EN
    localparam int SW = 16;
`else
    localparam int SW = 15;
`endif
    localparam logic [15:0] SETTLE_LAST  = 16'(SETTLE_CYCLES - 1);
    localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT_CYCLES - 1);
    localparam logic [0:0]  S_COLLECT    = 1'b0;
    localparam logic [0:0]  S_COMMIT     = 1'b1;

    logic [SW-1:0] w_raw;
    logic [SW-1:0] r_sync1, r_sync2, r_prev;
    logic [15:0]   r_settle;
    logic          w_accept;
    logic [7:0]    w_act;
    logic [6:0]    w_seg;
    logic          w_onehot, w_multi, w_seg_ok, w_blank;
    logic [3:0]    w_nib;
    logic [2:0]    w_idx;

    logic [0:0]    r_state;
    logic [7:0]    r_seen;
    logic [31:0]   r_shadow_val;
    logic [7:0]    r_shadow_blank;
    logic [31:0]   r_timeout;
    logic          r_err_pend;
    logic [31:0]   r_value;
    logic [7:0]    r_blank;
    logic          r_frame_valid, r_error, r_stale;

`ifdef SEVEN_SEGMENT_CAPTURE_DP_EN
    logic [7:0]    r_shadow_dp, r_dp;
    assign w_raw  = {dp_in, an_in, cat_in};
    assign dp_out = r_dp;
`else
    assign w_raw  = {an_in, cat_in};
`endif

    assign value_out       = r_value;
    assign blank_out       = r_blank;
    assign frame_valid_out = r_frame_valid;
    assign error_out       = r_error;
    assign stale_out       = r_stale;

    // Two-flop synchronizer; reset to all-ones so the display looks idle.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_sync1 <= '1;
            r_sync2 <= '1;
        end else begin
            r_sync1 <= w_raw;
            r_sync2 <= r_sync1;
        end
    end

    // Settle counter: restart on any change of the sampled lines, else count up and saturate.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_prev   <= '1;
            r_settle <= '0;
        end else begin
            r_prev <= r_sync2;
            if (r_sync2 != r_prev)
                r_settle <= '0;
            else if (r_settle != 16'hFFFF)
                r_settle <= r_settle + 16'd1;
        end
    end

    // r_prev holds the value that has been stable for r_settle+1 cycles.
    assign w_accept = (r_settle == SETTLE_LAST);
    assign w_act    = ~r_prev[14:7];
    assign w_seg    = ~r_prev[6:0];
    assign w_onehot = (w_act != 8'd0) && ((w_act & (w_act - 8'd1)) == 8'd0);
    assign w_multi  = (w_act != 8'd0) && !w_onehot;

    // Active digit index (only meaningful when the anode pattern is one-hot).
    always_comb begin
        w_idx = 3'd0;
        for (int i = 0; i < 8; i++)
            if (w_act[i]) w_idx = 3'(i);
    end

    // Segment pattern (g..a) to hex nibble; all-dark is a blank digit.
    always_comb begin
        w_nib    = 4'h0;
        w_blank  = 1'b0;
        w_seg_ok = 1'b1;
        case (w_seg)
            7'h3F: w_nib = 4'h0;
            7'h06: w_nib = 4'h1;
            7'h5B: w_nib = 4'h2;
            7'h4F: w_nib = 4'h3;
            7'h66: w_nib = 4'h4;
            7'h6D: w_nib = 4'h5;
            7'h7D: w_nib = 4'h6;
            7'h07: w_nib = 4'h7;
            7'h7F: w_nib = 4'h8;
            7'h6F: w_nib = 4'h9;
            7'h77: w_nib = 4'hA;
            7'h7C: w_nib = 4'hB;
            7'h39: w_nib = 4'hC;
            7'h5E: w_nib = 4'hD;
            7'h79: w_nib = 4'hE;
            7'h71: w_nib = 4'hF;
            7'h00: w_blank = 1'b1;
            default: w_seg_ok = 1'b0;
        endcase
    end

    // Frame FSM: shadow accumulation, timeout, error tracking and atomic commit.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_state        <= S_COLLECT;
            r_seen         <= '0;
            r_shadow_val   <= '0;
            r_shadow_blank <= '0;
            r_timeout      <= '0;
            r_err_pend     <= 1'b0;
            r_value        <= '0;
            r_blank        <= 8'hFF;
            r_frame_valid  <= 1'b0;
            r_error        <= 1'b0;
            r_stale        <= 1'b0;
`ifdef SEVEN_SEGMENT_CAPTURE_DP_EN
            r_shadow_dp    <= '0;
            r_dp           <= '0;
`endif
        end else begin
            r_frame_valid <= 1'b0;
            case (r_state)
                S_COLLECT: begin
                    if (w_accept && w_onehot) begin
                        r_timeout <= '0;
                    end else if (r_timeout == TIMEOUT_LAST) begin
                        r_timeout <= '0;
                        r_seen    <= '0;
                        r_stale   <= 1'b1;
                    end else begin
                        r_timeout <= r_timeout + 32'd1;
                    end

                    if (w_accept && w_multi) begin
                        r_error    <= 1'b1;
                        r_err_pend <= 1'b1;
                    end

                    if (w_accept && w_onehot) begin
                        if (w_seg_ok) begin
                            r_shadow_val[{w_idx, 2'b00} +: 4] <= w_nib;
                            r_shadow_blank[w_idx]             <= w_blank;
                            r_seen[w_idx]                     <= 1'b1;
`ifdef SEVEN_SEGMENT_CAPTURE_DP_EN
                            r_shadow_dp[w_idx]                <= ~r_prev[15];
`endif
                            if ((r_seen | w_act) == 8'hFF)
                                r_state <= S_COMMIT;
                        end else begin
                            r_error    <= 1'b1;
                            r_err_pend <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_value       <= r_shadow_val;
                    r_blank       <= r_shadow_blank;
`ifdef SEVEN_SEGMENT_CAPTURE_DP_EN
                    r_dp          <= r_shadow_dp;
`endif
                    r_frame_valid <= 1'b1;
                    // error_out survives this commit only if this frame saw an error
                    r_error       <= r_err_pend;
                    r_err_pend    <= 1'b0;
                    r_stale       <= 1'b0;
                    r_seen        <= '0;
                    r_state       <= S_COLLECT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seven_segment_capture.sv
// Bench for seven_segment_capture: directed scenarios plus randomized scans.
// A cycle-level reference model (run lengths, table lookup) predicts each
// committed frame into a queue; a negedge monitor pops and compares on every
// frame_valid_out pulse.

module tb_seven_segment_capture;
    localparam int SETTLE  = 16;
    localparam int TIMEOUT = 1000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  an  = 8'hFF;
    logic [6:0]  cat = 7'h7F;
    logic [31:0] value_out;
    logic [7:0]  blank_out;
    logic        frame_valid_out, error_out, stale_out;
`ifdef SEVEN_SEGMENT_CAPTURE_DP_EN
    logic        dp_in = 1'b1;
    logic [7:0]  dp_out;
`endif

    always #5 clk = ~clk;

    seven_segment_capture #(.SETTLE_CYCLES(SETTLE), .TIMEOUT_CYCLES(TIMEOUT)) dut (
        .clk_in(clk),
        .rst_in(rst),
        .an_in(an),
        .cat_in(cat),
`ifdef SEVEN_SEGMENT_CAPTURE_DP_EN
        .dp_in(dp_in),
        .dp_out(dp_out),
`endif
        .value_out(value_out),
        .blank_out(blank_out),
        .frame_valid_out(frame_valid_out),
        .error_out(error_out),
        .stale_out(stale_out)
    );

    typedef struct {
        logic [31:0] v;
        logic [7:0]  b;
        logic        e;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   n_fv     = 0;
    int   n_push   = 0;

    logic [6:0] seg_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    // reference model state
    logic [14:0] m_cur, m_prev;
    int          m_run, m_to;
    logic [7:0]  m_seen, m_blank;
    logic [31:0] m_val, m_last_val;
    logic        m_err, m_err_pend, m_stale;

    task automatic chk(string name, logic [31:0] got, logic [31:0] expv);
        n_checks++;
        if (got === expv) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, got, expv);
    endtask

    // -1: illegal pattern, 16: blank, else the hex digit
    function automatic int decode(logic [6:0] s);
        if (s == 7'h00) return 16;
        for (int j = 0; j < 16; j++)
            if (seg_tab[j] == s) return j;
        return -1;
    endfunction

    task automatic model_reset();
        m_cur = '0; m_prev = '0; m_run = 1; m_to = 0;
        m_seen = '0; m_blank = '0; m_val = '0; m_last_val = '0;
        m_err = 1'b0; m_err_pend = 1'b0; m_stale = 1'b0;
    endtask

    // One clock of the display as seen by the reference model.
    task automatic model_step();
        logic [7:0] act;
        logic [6:0] seg;
        bit         hit;
        int         idx, d;
        exp_t       e;
        hit = 0;
        if (m_cur == m_prev) begin
            if (m_run < 65535) m_run++;
        end else begin
            m_run = 1;
        end
        m_prev = m_cur;
        if (m_run == SETTLE) begin
            act = m_cur[14:7];
            seg = m_cur[6:0];
            if ($countones(act) > 1) begin
                m_err = 1'b1; m_err_pend = 1'b1;
            end else if ($countones(act) == 1) begin
                hit = 1;
                idx = 0;
                for (int i = 0; i < 8; i++) if (act[i]) idx = i;
                d = decode(seg);
                if (d < 0) begin
                    m_err = 1'b1; m_err_pend = 1'b1;
                end else begin
                    m_val[idx*4 +: 4] = (d == 16) ? 4'h0 : 4'(d);
                    m_blank[idx] = (d == 16);
                    m_seen[idx] = 1'b1;
                    if (m_seen == 8'hFF) begin
                        e.v = m_val; e.b = m_blank; e.e = m_err_pend;
                        exp_q.push_back(e);
                        n_push++;
                        m_err = m_err_pend; m_err_pend = 1'b0;
                        m_stale = 1'b0; m_seen = '0; m_last_val = m_val;
                    end
                end
            end
        end
        if (hit) begin
            m_to = 0;
        end else begin
            m_to++;
            if (m_to >= TIMEOUT) begin
                m_to = 0; m_seen = '0; m_stale = 1'b1;
            end
        end
    endtask

    task automatic drive(logic [7:0] act, logic [6:0] seg, int dwell);
        an = ~act;
        cat = ~seg;
        m_cur = {act, seg};
        repeat (dwell) begin
            model_step();
            @(posedge clk); #1;
        end
    endtask

    task automatic show(int d, logic [3:0] nib, bit blank, int dwell);
        logic [6:0] s;
        s = blank ? 7'h00 : seg_tab[nib];
        drive(8'(1 << d), s, dwell);
    endtask

    task automatic idle_wait();
        drive(8'h00, 7'h00, SETTLE + 10);
    endtask

    task automatic resume();
        model_step();
        @(posedge clk); #1;
    endtask

    task automatic check_reset_values(string tag);
        chk({tag, "_value"}, value_out, 32'h0);
        chk({tag, "_blank"}, {24'h0, blank_out}, 32'hFF);
        chk({tag, "_frame_valid"}, {31'h0, frame_valid_out}, 32'h0);
        chk({tag, "_error"}, {31'h0, error_out}, 32'h0);
        chk({tag, "_stale"}, {31'h0, stale_out}, 32'h0);
    endtask

    // Monitor: every commit must match the oldest predicted frame.
    always @(negedge clk) begin
        if (!rst && frame_valid_out) begin
            exp_t e;
            n_fv++;
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_commit: got commit value %0h, expected no commit", value_out);
            end else begin
                e = exp_q.pop_front();
                chk("commit_value", value_out, e.v);
                chk("commit_blank", {24'h0, blank_out}, {24'h0, e.b});
                chk("commit_error", {31'h0, error_out}, {31'h0, e.e});
                chk("commit_stale", {31'h0, stale_out}, 32'h0);
            end
        end
    end

    initial begin
        logic [31:0] v;
        logic [7:0]  bl;
        logic [6:0]  bs;
        int          ord [8];
        int          j, t;

        model_reset();
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_reset_values("reset");
        resume();

        // 1: plain frame, digits 0..7
        v = 32'h1234_ABCD;
        for (int d = 0; d < 8; d++) show(d, v[d*4 +: 4], 1'b0, 3*SETTLE);
        idle_wait();

        // 2: upper four digits dark, scanned 7..0
        v = 32'h0000_5678;
        for (int d = 7; d >= 0; d--) show(d, v[d*4 +: 4], d >= 4, 3*SETTLE);
        idle_wait();

        // 3: glitch on digit 3 blocks the frame, then a clean scan completes it
        v = 32'h9E3F_0C27;
        for (int d = 0; d < 8; d++) show(d, v[d*4 +: 4], 1'b0, (d == 3) ? SETTLE-2 : 3*SETTLE);
        idle_wait();
        @(negedge clk);
        chk("glitch_no_commit", n_fv, n_push);
        resume();
        for (int k = 0; k < 8; k++) show((k + 4) % 8, v[((k + 4) % 8)*4 +: 4], 1'b0, 20);
        idle_wait();

        // 4: two anodes active, then two clean zero frames
        drive(8'h03, seg_tab[1], 3*SETTLE);
        idle_wait();
        @(negedge clk);
        chk("bad_anode_error", {31'h0, error_out}, {31'h0, m_err});
        resume();
        for (int f = 0; f < 2; f++) begin
            for (int d = 0; d < 8; d++) show(d, 4'h0, 1'b0, 3*SETTLE);
            idle_wait();
        end

        // 5: scan stops after five digits -> timeout
        v = 32'h8765_4321;
        for (int d = 0; d < 5; d++) show(d, v[d*4 +: 4], 1'b0, 3*SETTLE);
        drive(8'h00, 7'h00, TIMEOUT + 100);
        @(negedge clk);
        chk("timeout_stale", {31'h0, stale_out}, {31'h0, m_stale});
        chk("timeout_value_held", value_out, m_last_val);
        chk("timeout_no_commit", n_fv, n_push);
        resume();
        for (int d = 0; d < 8; d++) show(d, v[d*4 +: 4], 1'b0, 3*SETTLE);
        idle_wait();
        @(negedge clk);
        chk("stale_cleared", {31'h0, stale_out}, {31'h0, m_stale});
        resume();

        // 6: reset after four digits discards them
        v = 32'hFEDC_BA98;
        for (int d = 0; d < 4; d++) show(d, v[d*4 +: 4], 1'b0, 3*SETTLE);
        drive(8'h00, 7'h00, 4);
        rst = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        rst = 1'b0;
        model_reset();
        @(negedge clk);
        check_reset_values("midreset");
        resume();
        for (int d = 4; d < 8; d++) show(d, v[d*4 +: 4], 1'b0, 3*SETTLE);
        idle_wait();
        @(negedge clk);
        chk("post_reset_no_commit", n_fv, n_push);
        resume();
        for (int d = 0; d < 4; d++) show(d, v[d*4 +: 4], 1'b0, 3*SETTLE);
        idle_wait();

        // 7: randomized scans with glitches, bad patterns and gaps
        for (int f = 0; f < 20; f++) begin
            v  = $urandom;
            bl = 8'($urandom & $urandom);
            for (int i = 0; i < 8; i++) ord[i] = i;
            for (int i = 7; i > 0; i--) begin
                j = $urandom_range(0, i);
                t = ord[i]; ord[i] = ord[j]; ord[j] = t;
            end
            for (int k = 0; k < 8; k++) begin
                if ($urandom_range(0, 7) == 0)
                    drive(8'(1 << $urandom_range(0, 7)), 7'($urandom_range(0, 127)),
                          $urandom_range(1, SETTLE-1));
                if ($urandom_range(0, 15) == 0) begin
                    do bs = 7'($urandom_range(1, 127)); while (decode(bs) >= 0);
                    drive(8'(1 << ord[k]), bs, $urandom_range(SETTLE, 2*SETTLE));
                end
                if ($urandom_range(0, 19) == 0)
                    drive(8'hC0, seg_tab[$urandom_range(0, 15)], $urandom_range(SETTLE, 2*SETTLE));
                if ($urandom_range(0, 9) == 0)
                    drive(8'h00, 7'h00, $urandom_range(1, 40));
                show(ord[k], v[ord[k]*4 +: 4], bl[ord[k]], $urandom_range(SETTLE, 3*SETTLE));
            end
        end

        drive(8'h00, 7'h00, 60);
        @(negedge clk);
        chk("all_frames_committed", exp_q.size(), 0);
        chk("commit_count", n_fv, n_push);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
